// File: rtl/rom_download_writer_if.sv
// HPS ioctl download stream and single-word SDRAM write port of rom_download_writer.
// ioctl_wr is a one-cycle strobe with no backpressure; mem_wr_req holds addr/data stable until mem_ack is sampled high.
interface rom_download_writer_if #(
    parameter int ADDR_W = 24
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_ack;

    // master: hps_io plus SDRAM controller side; slave: the download writer.
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  mem_wr_req, mem_addr, mem_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output mem_wr_req, mem_addr, mem_data
    );
endinterface

// File: rtl/rom_download_writer.sv
// Buffers the 16-bit ioctl ROM download in a small FIFO and replays it as single-word
// SDRAM write requests; rom_loaded rises once the download ended and every word was acked.
module rom_download_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 24
) (
    input  logic                 clk_sys_99_287,
    input  logic                 reset,
    rom_download_writer_if.slave bus,
    output logic                 busy,
    output logic                 rom_loaded,
    output logic                 overflow,
    output logic [ADDR_W-1:0]    word_count,
    output logic                 dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 16;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              dl_q;
    logic              dl_start;
    logic              dl_end;
    logic              done_pending;
    logic              load_done;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_data_q;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = bus.ioctl_addr[0];

    // full comes from the registered count, so a same-cycle pop never frees a slot for a push.
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign dl_start   = bus.ioctl_download & ~dl_q;
    assign dl_end     = ~bus.ioctl_download & dl_q;
    assign push       = bus.ioctl_wr & bus.ioctl_download & ~fifo_full;
    assign drop       = bus.ioctl_wr & bus.ioctl_download & fifo_full;
    assign load_done  = done_pending & fifo_empty & (state == IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_99_287 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys_99_287) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.ioctl_addr[ADDR_W:1], bus.ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys_99_287 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                mem_addr_q <= fifo_mem[rd_ptr][ENT_W-1:16];
                mem_data_q <= fifo_mem[rd_ptr][15:0];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new download clears the status but leaves queued words from the previous load draining.
    always_ff @(posedge clk_sys_99_287 or posedge reset) begin
        if (reset) begin
            dl_q         <= 1'b0;
            done_pending <= 1'b0;
            rom_loaded   <= 1'b0;
            overflow     <= 1'b0;
            word_count   <= '0;
        end else begin
            dl_q <= bus.ioctl_download;
            if (dl_start) begin
                done_pending <= 1'b0;
                rom_loaded   <= 1'b0;
                overflow     <= drop;
                word_count   <= push ? ADDR_W'(1) : '0;
            end else begin
                if (dl_end) begin
                    done_pending <= 1'b1;
                end
                if (load_done) begin
                    rom_loaded   <= 1'b1;
                    done_pending <= 1'b0;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (push && (word_count != '1)) begin
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end

    assign bus.mem_wr_req = (state == REQ);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign busy           = !fifo_empty || (state == REQ);
    assign dbg_state      = state;
endmodule

// File: tb/tb_rom_download_writer.sv
// Self-checking bench for rom_download_writer: directed scenarios plus randomized downloads,
// compared cycle by cycle against a queue-based reference model and an in-order write scoreboard.
`timescale 1ns/1ps
module tb_rom_download_writer;
    localparam int DEPTH = 8;
    localparam int AW    = 24;

    logic          clk_sys_99_287 = 1'b0;
    logic          reset          = 1'b0;
    logic          busy;
    logic          rom_loaded;
    logic          overflow;
    logic [AW-1:0] word_count;
    logic          dbg_state;

    rom_download_writer_if #(.ADDR_W(AW)) bus ();

    rom_download_writer #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk_sys_99_287 (clk_sys_99_287),
        .reset          (reset),
        .bus            (bus),
        .busy           (busy),
        .rom_loaded     (rom_loaded),
        .overflow       (overflow),
        .word_count     (word_count),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clk_sys_99_287 = ~clk_sys_99_287;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words waiting in the buffer, plus at most one word on the memory port.
    logic [39:0]   m_q[$];
    logic [39:0]   exp_q[$];
    logic [39:0]   m_cur;
    bit            m_inflight;
    bit            m_dl_prev;
    bit            m_done;
    bit            m_loaded;
    bit            m_ovf;
    logic [AW-1:0] m_wc;
    bit            s_start, s_stop, s_acc, s_drop, s_issue, s_fin, s_ld;

    always @(posedge clk_sys_99_287 or posedge reset) begin
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_cur      = '0;
            m_inflight = 1'b0;
            m_dl_prev  = 1'b0;
            m_done     = 1'b0;
            m_loaded   = 1'b0;
            m_ovf      = 1'b0;
            m_wc       = '0;
        end else begin
            s_start = bus.ioctl_download && !m_dl_prev;
            s_stop  = !bus.ioctl_download && m_dl_prev;
            s_acc   = bus.ioctl_wr && bus.ioctl_download && (m_q.size() < DEPTH);
            s_drop  = bus.ioctl_wr && bus.ioctl_download && (m_q.size() == DEPTH);
            s_issue = !m_inflight && (m_q.size() > 0);
            s_fin   = m_inflight && bus.mem_ack;
            s_ld    = m_done && (m_q.size() == 0) && !m_inflight;
            if (s_fin) m_inflight = 1'b0;
            if (s_issue) begin
                m_cur      = m_q.pop_front();
                m_inflight = 1'b1;
            end
            if (s_ld) begin
                m_loaded = 1'b1;
                m_done   = 1'b0;
            end
            if (s_stop) m_done = 1'b1;
            if (s_start) begin
                m_loaded = 1'b0;
                m_done   = 1'b0;
                m_ovf    = 1'b0;
                m_wc     = '0;
            end
            if (s_acc) begin
                m_q.push_back({bus.ioctl_addr[24:1], bus.ioctl_dout});
                exp_q.push_back({bus.ioctl_addr[24:1], bus.ioctl_dout});
                if (m_wc != {AW{1'b1}}) m_wc = m_wc + 1'b1;
            end
            if (s_drop) m_ovf = 1'b1;
            m_dl_prev = bus.ioctl_download;
        end
    end

    // scoreboard and per-cycle output checks, sampled on the falling edge
    always @(negedge clk_sys_99_287) begin
        if (chk_en && !reset) begin
            check("mem_wr_req", bus.mem_wr_req, m_inflight);
            if (m_inflight) begin
                check("mem_addr", bus.mem_addr, m_cur[39:16]);
                check("mem_data", bus.mem_data, m_cur[15:0]);
            end
            check("busy", busy, (m_q.size() != 0) || m_inflight);
            check("rom_loaded", rom_loaded, m_loaded);
            check("overflow", overflow, m_ovf);
            check("word_count", word_count, m_wc);
            if (bus.mem_wr_req && bus.mem_ack) begin
                if (exp_q.size() == 0) check("sb_unexpected_write", exp_q.size(), 1);
                else check("sb_write", {bus.mem_addr, bus.mem_data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_sys_99_287);
        #1;
    endtask

    task automatic wait_loaded(input int limit, input int ack_pct, input bit junk_wr);
        int n = 0;
        while (!rom_loaded && n < limit) begin
            bus.mem_ack    = ($urandom_range(99) < ack_pct);
            bus.ioctl_wr   = junk_wr && ($urandom_range(1) == 1);
            bus.ioctl_addr = 25'($urandom);
            bus.ioctl_dout = 16'($urandom);
            tick();
            n++;
        end
        bus.ioctl_wr = 1'b0;
        bus.mem_ack  = 1'b0;
        check("rom_loaded_wait", rom_loaded, 1'b1);
        check("drained", exp_q.size(), 0);
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (!bus.mem_wr_req && n < limit) begin
            tick();
            n++;
        end
        check("wait_req", bus.mem_wr_req, 1'b1);
    endtask

    task automatic random_download(input int n_cyc, input int wr_pct, input int ack_pct);
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n_cyc; i++) begin
            bus.ioctl_wr   = ($urandom_range(99) < wr_pct);
            bus.ioctl_addr = 25'($urandom);
            bus.ioctl_dout = 16'($urandom);
            bus.mem_ack    = ($urandom_range(99) < ack_pct);
            tick();
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        wait_loaded(600, ack_pct, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_pct[4]  = '{30, 60, 90, 100};
        int ack_pct[4] = '{80, 50, 30, 20};

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.mem_ack        = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_req", bus.mem_wr_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_loaded", rom_loaded, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_word_count", word_count, '0);
        repeat (3) @(posedge clk_sys_99_287);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // zero-word download
        bus.ioctl_download = 1'b1;
        tick();
        tick();
        bus.ioctl_download = 1'b0;
        wait_loaded(20, 0, 1'b0);

        // single write, ack three cycles after the request
        bus.ioctl_download = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h000010;
        bus.ioctl_dout = 16'hBEEF;
        tick();
        bus.ioctl_wr = 1'b0;
        check("t1_req_n1", bus.mem_wr_req, 1'b0);
        tick();
        check("t1_req_n2", bus.mem_wr_req, 1'b1);
        check("t1_addr", bus.mem_addr, 24'h000008);
        check("t1_data", bus.mem_data, 16'hBEEF);
        tick();
        check("t1_req_n3", bus.mem_wr_req, 1'b1);
        tick();
        check("t1_req_n4", bus.mem_wr_req, 1'b1);
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("t1_req_drop", bus.mem_wr_req, 1'b0);
        bus.ioctl_download = 1'b0;
        wait_loaded(20, 0, 1'b0);

        // back-to-back writes with ack held low; one word sits on the memory port
        bus.ioctl_download = 1'b1;
        tick();
        bus.ioctl_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ioctl_addr = 25'(i * 2);
            bus.ioctl_dout = 16'($urandom);
            tick();
        end
        check("t2_ovf_after8", overflow, 1'b0);
        check("t2_wc_after8", word_count, 24'd8);
        for (int i = 8; i < 10; i++) begin
            bus.ioctl_addr = 25'(i * 2);
            bus.ioctl_dout = 16'($urandom);
            tick();
        end
        bus.ioctl_wr = 1'b0;
        check("t2_ovf_after10", overflow, 1'b1);
        check("t2_wc_after10", word_count, 24'd9);
        bus.ioctl_download = 1'b0;
        wait_loaded(100, 100, 1'b0);

        // 20-word burst with ack held high
        bus.ioctl_download = 1'b1;
        tick();
        bus.mem_ack  = 1'b1;
        bus.ioctl_wr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.ioctl_addr = 25'($urandom);
            bus.ioctl_dout = 16'(i);
            tick();
        end
        bus.ioctl_wr = 1'b0;
        check("t3_overflow", overflow, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_loaded(100, 100, 1'b0);

        // writes while not downloading are ignored; a new download clears the status
        bus.ioctl_wr = 1'b1;
        repeat (3) tick();
        bus.ioctl_wr = 1'b0;
        check("t6_ign_busy", busy, 1'b0);
        check("t6_ign_wc", word_count, m_wc);
        bus.ioctl_download = 1'b1;
        tick();
        check("t6_loaded_clr", rom_loaded, 1'b0);
        check("t6_ovf_clr", overflow, 1'b0);
        check("t6_wc_clr", word_count, '0);

        // download ends with words still pending
        bus.mem_ack  = 1'b0;
        bus.ioctl_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ioctl_addr = 25'($urandom);
            bus.ioctl_dout = 16'($urandom);
            tick();
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_not_loaded", rom_loaded, 1'b0);
        end
        check("t4_busy", busy, 1'b1);
        wait_loaded(100, 100, 1'b0);

        // randomized downloads
        for (int k = 0; k < 4; k++) begin
            random_download(40 + k * 15, wr_pct[k], ack_pct[k]);
        end

        // asynchronous reset in the middle of a request
        bus.ioctl_download = 1'b1;
        tick();
        bus.ioctl_wr = 1'b1;
        repeat (3) tick();
        bus.ioctl_wr = 1'b0;
        wait_req(10);
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t5_req_async", bus.mem_wr_req, 1'b0);
        check("t5_busy_async", busy, 1'b0);
        check("t5_loaded_async", rom_loaded, 1'b0);
        repeat (2) tick();
        bus.ioctl_download = 1'b0;
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) tick();
        check("t5_busy_after", busy, 1'b0);
        check("t5_wc_after", word_count, '0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
